uid_allocator: RTL and testbench



---
 rtl/uid_allocator.sv | 177 +++++++++++++++++
 tb/tb_uid_allocator.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uid_allocator.sv
// uid_allocator: maps original AXI master IDs onto {row, col} unique IDs.
// Each row binds one master ID while it has outstanding transactions. Each
// row is a circular queue of column slots released strictly in issue order.
// The allocation port is decided only from registered state, so the release
// port never reaches alloc_ready/alloc_uid combinationally.
module uid_allocator #(
    parameter int ID_WIDTH = 4,
    parameter int NUM_ROWS = 16,
    parameter int NUM_COLS = 16,
    localparam int RW    = $clog2(NUM_ROWS),
    localparam int CW    = $clog2(NUM_COLS),
    localparam int UID_W = RW + CW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_valid,
    input  logic [ID_WIDTH-1:0] alloc_id,
    output logic                alloc_ready,
    output logic [UID_W-1:0]    alloc_uid,
    input  logic                rel_valid,
    input  logic [UID_W-1:0]    rel_uid,
    output logic                rel_err,
    output logic [RW:0]         rows_used,
    output logic                empty
);

    localparam logic [CW:0]   FULL_COUNT = (CW+1)'(NUM_COLS);
    localparam logic [CW:0]   CNT_ONE    = (CW+1)'(1);
    localparam logic [CW-1:0] COL_ONE    = CW'(1);

    // Per-row state
    logic [NUM_ROWS-1:0] used_q, used_d;
    logic [ID_WIDTH-1:0] id_q    [NUM_ROWS];
    logic [ID_WIDTH-1:0] id_d    [NUM_ROWS];
    logic [CW-1:0]       head_q  [NUM_ROWS];
    logic [CW-1:0]       head_d  [NUM_ROWS];
    logic [CW-1:0]       tail_q  [NUM_ROWS];
    logic [CW-1:0]       tail_d  [NUM_ROWS];
    logic [CW:0]         count_q [NUM_ROWS];
    logic [CW:0]         count_d [NUM_ROWS];

    // Registered status outputs
    logic          rel_err_q, rel_err_d;
    logic [RW:0]   rows_used_q, rows_used_d;
    logic          empty_q, empty_d;

    // Lookup results
    logic          hit;
    logic [RW-1:0] hit_row;
    logic          free_found;
    logic [RW-1:0] free_row;
    logic [RW-1:0] sel_row;
    logic          alloc_fire;

    // Release decode
    logic [RW-1:0] rel_row;
    logic [CW-1:0] rel_col;
    logic          rel_legal;
    logic          rel_fire;

    // Per-row event strobes for this cycle
    logic [NUM_ROWS-1:0] alloc_here;
    logic [NUM_ROWS-1:0] rel_here;

    // Find the row bound to the requesting ID and the lowest-index free row.
    always_comb begin
        hit        = 1'b0;
        hit_row    = '0;
        free_found = 1'b0;
        free_row   = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (used_q[r] && (id_q[r] == alloc_id)) begin
                hit     = 1'b1;
                hit_row = RW'(r);
            end
        end
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (!used_q[r]) begin
                free_found = 1'b1;
                free_row   = RW'(r);
            end
        end
    end

    // Drive the allocation handshake from registered state only.
    always_comb begin
        sel_row     = hit ? hit_row : free_row;
        alloc_ready = 1'b0;
        alloc_uid   = '0;
        if (hit) begin
            alloc_ready = (count_q[hit_row] != FULL_COUNT);
            alloc_uid   = {hit_row, tail_q[hit_row]};
        end else if (free_found) begin
            alloc_ready = 1'b1;
            alloc_uid   = {free_row, tail_q[free_row]};
        end
        alloc_fire = alloc_valid && alloc_ready;
    end

    // A release is legal only for the oldest outstanding slot of a bound row.
    always_comb begin
        rel_row   = rel_uid[UID_W-1:CW];
        rel_col   = rel_uid[CW-1:0];
        rel_legal = used_q[rel_row] && (count_q[rel_row] != '0) &&
                    (rel_col == head_q[rel_row]);
        rel_fire  = rel_valid && rel_legal;
        for (int r = 0; r < NUM_ROWS; r++) begin
            alloc_here[r] = alloc_fire && (sel_row == RW'(r));
            rel_here[r]   = rel_fire && (rel_row == RW'(r));
        end
    end

    // Next-state for every row plus the registered status outputs.
    always_comb begin
        used_d  = used_q;
        id_d    = id_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (alloc_here[r]) begin
                tail_d[r] = tail_q[r] + COL_ONE;
                if (!hit) begin
                    used_d[r] = 1'b1;
                    id_d[r]   = alloc_id;
                end
            end
            if (rel_here[r]) begin
                head_d[r] = head_q[r] + COL_ONE;
            end
            if (alloc_here[r] && !rel_here[r]) begin
                count_d[r] = count_q[r] + CNT_ONE;
            end else if (rel_here[r] && !alloc_here[r]) begin
                count_d[r] = count_q[r] - CNT_ONE;
                if (count_q[r] == CNT_ONE) begin
                    used_d[r] = 1'b0;
                end
            end
        end
        rel_err_d   = rel_valid && !rel_legal;
        rows_used_d = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            rows_used_d = rows_used_d + {{RW{1'b0}}, used_d[r]};
        end
        empty_d = (rows_used_d == '0);
    end

    // State registers; reset drops every binding at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            used_q <= '0;
            for (int r = 0; r < NUM_ROWS; r++) begin
                id_q[r]    <= '0;
                head_q[r]  <= '0;
                tail_q[r]  <= '0;
                count_q[r] <= '0;
            end
            rel_err_q   <= 1'b0;
            rows_used_q <= '0;
            empty_q     <= 1'b1;
        end else begin
            used_q      <= used_d;
            id_q        <= id_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            rel_err_q   <= rel_err_d;
            rows_used_q <= rows_used_d;
            empty_q     <= empty_d;
        end
    end

    assign rel_err   = rel_err_q;
    assign rows_used = rows_used_q;
    assign empty     = empty_q;

endmodule

// File: tb/tb_uid_allocator.sv
// Testbench for uid_allocator. A per-row queue of outstanding columns serves
// as the reference: a row is bound while its queue is non-empty, the next
// column is a retained modulo counter, and a release must match the queue front.
module tb_uid_allocator;

    localparam int ID_W = 5;
    localparam int NR   = 16;
    localparam int NC   = 16;
    localparam int UW   = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            alloc_valid = 1'b0;
    logic [ID_W-1:0] alloc_id = '0;
    logic            alloc_ready;
    logic [UW-1:0]   alloc_uid;
    logic            rel_valid = 1'b0;
    logic [UW-1:0]   rel_uid = '0;
    logic            rel_err;
    logic [4:0]      rows_used;
    logic            empty;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    int mq [NR][$];
    int mid [NR];
    int mnext [NR];

    // Values captured by the most recent applyStimulus call
    logic          obs_ready, exp_ready;
    logic [UW-1:0] obs_uid, exp_uid;
    logic          obs_err, exp_err;
    logic [4:0]    obs_rows;
    int            exp_rows;
    logic          obs_empty, exp_empty;

    uid_allocator #(
        .ID_WIDTH(ID_W),
        .NUM_ROWS(NR),
        .NUM_COLS(NC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_valid (alloc_valid),
        .alloc_id    (alloc_id),
        .alloc_ready (alloc_ready),
        .alloc_uid   (alloc_uid),
        .rel_valid   (rel_valid),
        .rel_uid     (rel_uid),
        .rel_err     (rel_err),
        .rows_used   (rows_used),
        .empty       (empty)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic void model_reset();
        for (int r = 0; r < NR; r++) begin
            mq[r].delete();
            mid[r]   = 0;
            mnext[r] = 0;
        end
    endfunction

    function automatic int model_rows();
        int n = 0;
        for (int r = 0; r < NR; r++) if (mq[r].size() > 0) n++;
        return n;
    endfunction

    function automatic void predict(input int aid, output logic rdy, output logic [UW-1:0] uid);
        rdy = 1'b0;
        uid = '0;
        for (int r = 0; r < NR; r++) begin
            if (mq[r].size() > 0 && mid[r] == aid) begin
                rdy = (mq[r].size() < NC);
                uid = UW'(r * NC + mnext[r]);
                return;
            end
        end
        for (int r = 0; r < NR; r++) begin
            if (mq[r].size() == 0) begin
                rdy = 1'b1;
                uid = UW'(r * NC + mnext[r]);
                return;
            end
        end
    endfunction

    // One clock cycle of stimulus, entered and left at a falling edge.
    task automatic applyStimulus(input logic av, input int aid, input logic rv, input int ruid);
        int   row, col, ar;
        logic legal;
        alloc_valid = av;
        alloc_id    = ID_W'(aid);
        rel_valid   = rv;
        rel_uid     = UW'(ruid);
        #1;
        obs_ready = alloc_ready;
        obs_uid   = alloc_uid;
        predict(aid, exp_ready, exp_uid);
        row   = ruid / NC;
        col   = ruid % NC;
        legal = 1'b0;
        if (mq[row].size() > 0) legal = (mq[row][0] == col);
        @(posedge clk);
        if (rv && legal) void'(mq[row].pop_front());
        if (av && exp_ready) begin
            ar = int'(exp_uid) / NC;
            if (mq[ar].size() == 0) mid[ar] = aid;
            mq[ar].push_back(int'(exp_uid) % NC);
            mnext[ar] = (mnext[ar] + 1) % NC;
        end
        exp_err   = rv && !legal;
        exp_rows  = model_rows();
        exp_empty = (exp_rows == 0);
        @(negedge clk);
        obs_err   = rel_err;
        obs_rows  = rows_used;
        obs_empty = empty;
        alloc_valid = 1'b0;
        rel_valid   = 1'b0;
    endtask

    task automatic resetDut();
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        tests_run++;
        if (rows_used !== 5'd0 || empty !== 1'b1 || rel_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: rows_used=%0d empty=%b rel_err=%b, required 0/1/0", rows_used, empty, rel_err);
        end
        rst = 1'b1;
        applyStimulus(1'b1, 7, 1'b0, 0);
        tests_run++;
        if (obs_ready !== 1'b1 || obs_uid !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL reset_first_alloc: ready=%b uid=%h, required 1/00", obs_ready, obs_uid);
        end
        tests_run++;
        if (obs_rows !== 5'd1) begin
            tests_failed++;
            $display("[TB] FAIL reset_rows_after_alloc: got %0d required 1", obs_rows);
        end
    endtask

    task automatic test_basic();
        logic [UW-1:0] want [3];
        int            ids [3];
        want = '{8'h00, 8'h01, 8'h10};
        ids  = '{5, 5, 9};
        resetDut();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, ids[i], 1'b0, 0);
            tests_run++;
            if (obs_ready !== 1'b1 || obs_uid !== want[i]) begin
                tests_failed++;
                $display("[TB] FAIL basic_uid[%0d]: ready=%b uid=%h, required 1/%h", i, obs_ready, obs_uid, want[i]);
            end
        end
        tests_run++;
        if (obs_rows !== 5'd2 || obs_empty !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL basic_rows: rows_used=%0d empty=%b, required 2/0", obs_rows, obs_empty);
        end
    endtask

    task automatic test_column_full();
        resetDut();
        for (int i = 0; i < NC; i++) begin
            applyStimulus(1'b1, 3, 1'b0, 0);
            tests_run++;
            if (obs_ready !== 1'b1 || obs_uid !== UW'(i)) begin
                tests_failed++;
                $display("[TB] FAIL colfull_uid[%0d]: ready=%b uid=%h, required 1/%h", i, obs_ready, obs_uid, UW'(i));
            end
        end
        // A release in the same cycle must not open the full row combinationally.
        applyStimulus(1'b1, 3, 1'b1, 8'h00);
        tests_run++;
        if (obs_ready !== 1'b0 || obs_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL colfull_17th: ready=%b rel_err=%b, required 0/0", obs_ready, obs_err);
        end
        applyStimulus(1'b1, 3, 1'b0, 0);
        tests_run++;
        if (obs_ready !== 1'b1 || obs_uid !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL colfull_wrap: ready=%b uid=%h, required 1/00", obs_ready, obs_uid);
        end
    endtask

    task automatic test_rows_full();
        resetDut();
        for (int r = 0; r < NR; r++) begin
            applyStimulus(1'b1, r, 1'b0, 0);
            tests_run++;
            if (obs_uid !== UW'(r * NC)) begin
                tests_failed++;
                $display("[TB] FAIL rowsfull_fill[%0d]: uid=%h required %h", r, obs_uid, UW'(r * NC));
            end
        end
        applyStimulus(1'b1, 20, 1'b0, 0);
        tests_run++;
        if (obs_ready !== 1'b0 || obs_uid !== 8'h00 || obs_rows !== 5'd16) begin
            tests_failed++;
            $display("[TB] FAIL rowsfull_newid: ready=%b uid=%h rows=%0d, required 0/00/16", obs_ready, obs_uid, obs_rows);
        end
        applyStimulus(1'b1, 4, 1'b0, 0);
        tests_run++;
        if (obs_ready !== 1'b1 || obs_uid !== 8'h41) begin
            tests_failed++;
            $display("[TB] FAIL rowsfull_hit: ready=%b uid=%h, required 1/41", obs_ready, obs_uid);
        end
        applyStimulus(1'b1, 21, 1'b1, 8'h70);
        tests_run++;
        if (obs_ready !== 1'b0 || obs_err !== 1'b0 || obs_rows !== 5'd15) begin
            tests_failed++;
            $display("[TB] FAIL rowsfull_release_cycle: ready=%b rel_err=%b rows=%0d, required 0/0/15", obs_ready, obs_err, obs_rows);
        end
        applyStimulus(1'b1, 21, 1'b0, 0);
        tests_run++;
        if (obs_ready !== 1'b1 || obs_uid !== 8'h71 || obs_rows !== 5'd16) begin
            tests_failed++;
            $display("[TB] FAIL rowsfull_reuse: ready=%b uid=%h rows=%0d, required 1/71/16", obs_ready, obs_uid, obs_rows);
        end
    endtask

    task automatic test_illegal_release();
        resetDut();
        applyStimulus(1'b1, 5, 1'b0, 0);
        applyStimulus(1'b0, 0, 1'b1, 8'h01);
        tests_run++;
        if (obs_err !== 1'b1 || obs_rows !== 5'd1) begin
            tests_failed++;
            $display("[TB] FAIL illegal_col: rel_err=%b rows=%0d, required 1/1", obs_err, obs_rows);
        end
        applyStimulus(1'b0, 0, 1'b0, 0);
        tests_run++;
        if (obs_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL illegal_pulse_width: rel_err=%b required 0", obs_err);
        end
        applyStimulus(1'b0, 0, 1'b1, 8'h30);
        tests_run++;
        if (obs_err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL illegal_unused_row: rel_err=%b required 1", obs_err);
        end
        applyStimulus(1'b1, 5, 1'b0, 0);
        tests_run++;
        if (obs_uid !== 8'h01 || obs_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL illegal_state_kept: uid=%h rel_err=%b, required 01/0", obs_uid, obs_err);
        end
        applyStimulus(1'b0, 0, 1'b1, 8'h00);
        applyStimulus(1'b0, 0, 1'b1, 8'h01);
        tests_run++;
        if (obs_err !== 1'b0 || obs_empty !== 1'b1 || obs_rows !== 5'd0) begin
            tests_failed++;
            $display("[TB] FAIL illegal_drain: rel_err=%b empty=%b rows=%0d, required 0/1/0", obs_err, obs_empty, obs_rows);
        end
    endtask

    task automatic test_back_to_back();
        resetDut();
        applyStimulus(1'b1, 5, 1'b0, 0);
        applyStimulus(1'b1, 5, 1'b1, 8'h00);
        tests_run++;
        if (obs_ready !== 1'b1 || obs_uid !== 8'h01 || obs_err !== 1'b0 || obs_rows !== 5'd1) begin
            tests_failed++;
            $display("[TB] FAIL same_row: ready=%b uid=%h rel_err=%b rows=%0d, required 1/01/0/1", obs_ready, obs_uid, obs_err, obs_rows);
        end
        applyStimulus(1'b0, 0, 1'b1, 8'h00);
        tests_run++;
        if (obs_err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL same_row_head_moved: rel_err=%b required 1", obs_err);
        end
        // Row 0 empties in the same cycle another ID binds: the new ID takes row 1.
        applyStimulus(1'b1, 9, 1'b1, 8'h01);
        tests_run++;
        if (obs_uid !== 8'h10 || obs_err !== 1'b0 || obs_rows !== 5'd1 || obs_empty !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL diff_rows: uid=%h rel_err=%b rows=%0d empty=%b, required 10/0/1/0", obs_uid, obs_err, obs_rows, obs_empty);
        end
    endtask

    task automatic test_reset_mid();
        resetDut();
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, i, 1'b0, 0);
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if (empty !== 1'b1 || rows_used !== 5'd0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_immediate: empty=%b rows=%0d, required 1/0", empty, rows_used);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        applyStimulus(1'b1, 11, 1'b0, 0);
        tests_run++;
        if (obs_ready !== 1'b1 || obs_uid !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL midreset_alloc: ready=%b uid=%h, required 1/00", obs_ready, obs_uid);
        end
        applyStimulus(1'b0, 0, 1'b1, 8'h10);
        tests_run++;
        if (obs_err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midreset_stale_release: rel_err=%b required 1", obs_err);
        end
    endtask

    task automatic test_random();
        logic av, rv;
        int   aid, ruid;
        int   bound [$];
        resetDut();
        for (int cyc = 0; cyc < 400; cyc++) begin
            av  = ($urandom_range(0, 3) != 0);
            aid = ($urandom_range(0, 9) != 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(16, 31));
            rv  = ($urandom_range(0, 1) == 1);
            bound.delete();
            for (int r = 0; r < NR; r++) if (mq[r].size() > 0) bound.push_back(r);
            if (bound.size() > 0 && $urandom_range(0, 3) != 0) begin
                ruid = bound[$urandom_range(0, bound.size() - 1)];
                ruid = ruid * NC + mq[ruid][0];
            end else begin
                ruid = int'($urandom_range(0, 255));
            end
            applyStimulus(av, aid, rv, ruid);
            if (av) begin
                tests_run++;
                if (obs_ready !== exp_ready || obs_uid !== exp_uid) begin
                    tests_failed++;
                    $display("[TB] FAIL random_alloc cyc %0d id %0d: ready=%b uid=%h, required %b/%h", cyc, aid, obs_ready, obs_uid, exp_ready, exp_uid);
                end
            end
            tests_run++;
            if (obs_err !== exp_err || int'(obs_rows) !== exp_rows || obs_empty !== exp_empty) begin
                tests_failed++;
                $display("[TB] FAIL random_status cyc %0d: rel_err=%b rows=%0d empty=%b, required %b/%0d/%b", cyc, obs_err, obs_rows, obs_empty, exp_err, exp_rows, exp_empty);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_column_full();
        test_rows_full();
        test_illegal_release();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
